bg_stream_fetch: RTL and testbench

- Parametrised successor to the background-picture fetch logic in the arcade top level.
- Streams a full-frame background image from the SDRAM read channel into a prefetch FIFO and delivers one RGBA pixel per active `ce_pix`.
- Additions over the previous logic:
  - request/acknowledge handshake;
  - configurable base address;
  - 32bpp RGBA and 16bpp RGB565 modes;
  - underrun reporting.
- Sits between the SDRAM controller channel and the foreground/background mux feeding `arcade_video`.

---
 rtl/bg_stream_pkg.sv | 32 +++
 rtl/bg_fifo.sv | 59 +++++
 rtl/bg_stream_fetch.sv | 185 ++++++++++++++++++
 tb/tb_bg_stream_fetch.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_stream_pkg.sv
// Shared types and helpers for the background stream fetcher.
package bg_stream_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;

    localparam logic MODE_RGBA32 = 1'b1;
    localparam logic MODE_RGB565 = 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

    // Replicate the top bits into the low bits so full-scale stays full-scale.
    function automatic pixel_t rgb565_expand(input logic [HALF_W-1:0] p);
        pixel_t px;
        px.r = {p[4:0],   p[4:2]};
        px.g = {p[10:5],  p[10:9]};
        px.b = {p[15:11], p[15:13]};
        px.a = 8'hFF;
        return px;
    endfunction

endpackage

// File: rtl/bg_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry.
module bg_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/bg_stream_fetch.sv
// Streams a background frame from SDRAM through a prefetch FIFO, one RGBA pixel per ce_pix.
module bg_stream_fetch
    import bg_stream_pkg::*;
#(
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              mode32,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ce_pix,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              vs,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_data,
    output logic [7:0]        bg_r,
    output logic [7:0]        bg_g,
    output logic [7:0]        bg_b,
    output logic [7:0]        bg_a,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] fetch_addr_next;
    logic              discard_q;
    logic              discard_next;
    logic              vs_q;
    logic              frame_start;
    logic              mode32_q;
    logic              half_q;
    logic              half_next;
    logic              underrun_next;
    logic              pop_fire;
    pixel_t            pix_q;
    pixel_t            pix_next;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              fifo_empty;
    logic              fifo_full;
    logic [WORD_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;

    assign frame_start = vs & ~vs_q;
    assign pop_fire    = ce_pix & ~hblank & ~vblank & enable;
    assign fifo_flush  = frame_start | ~enable;

    bg_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .din     (mem_data),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Frame-edge detection; pixel format is latched only at frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q     <= 1'b0;
            mode32_q <= MODE_RGB565;
        end else begin
            vs_q <= vs;
            if (frame_start) mode32_q <= mode32;
        end
    end

    // Fetch FSM state, address and discard registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fetch_addr <= '0;
            discard_q  <= 1'b0;
        end else begin
            state      <= state_next;
            mem_req    <= (state_next == ST_REQ);
            fetch_addr <= fetch_addr_next;
            discard_q  <= discard_next;
            if ((state_next == ST_REQ) && (state == ST_IDLE)) mem_addr <= fetch_addr_next;
        end
    end

    // One request in flight at most, so IDLE only needs the FIFO count.
    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        discard_next    = discard_q;
        fifo_push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && (fifo_count < CNT_W'(FIFO_DEPTH))) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_next = ST_IDLE;
                    if (discard_q) begin
                        discard_next = 1'b0;
                    end else begin
                        fifo_push       = 1'b1;
                        fetch_addr_next = fetch_addr + ADDR_W'(2);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A restart abandons the in-flight word; a same-cycle ack is simply flushed.
        if (frame_start) begin
            fetch_addr_next = base_addr;
            discard_next    = (state == ST_REQ) && !mem_ack;
        end
        if (!enable) begin
            state_next   = ST_IDLE;
            discard_next = 1'b0;
        end
    end

    // Pixel datapath: format conversion, pop control and underrun detection.
    always_comb begin
        pix_next      = pix_q;
        half_next     = half_q;
        underrun_next = underrun;
        fifo_pop      = 1'b0;
        if (ce_pix) begin
            pix_next = '0;
            if (pop_fire) begin
                if (fifo_empty) begin
                    underrun_next = 1'b1;
                end else if (mode32_q == MODE_RGBA32) begin
                    pix_next = pixel_t'(fifo_dout);
                    fifo_pop = 1'b1;
                end else begin
                    pix_next  = rgb565_expand(half_q ? fifo_dout[WORD_W-1:HALF_W]
                                                     : fifo_dout[HALF_W-1:0]);
                    fifo_pop  = half_q;
                    half_next = ~half_q;
                end
            end
        end
        if (frame_start) begin
            half_next     = 1'b0;
            underrun_next = 1'b0;
        end
        if (!enable) half_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q    <= '0;
            half_q   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            pix_q    <= pix_next;
            half_q   <= half_next;
            underrun <= underrun_next;
        end
    end

    assign bg_r = pix_q.r;
    assign bg_g = pix_q.g;
    assign bg_b = pix_q.b;
    assign bg_a = pix_q.a;

    push_has_space: assert property (@(posedge clk) disable iff (!reset_n)
        !(fifo_push && !fifo_flush && fifo_full));

endmodule

// File: tb/tb_bg_stream_fetch.sv
// Randomized bench for bg_stream_fetch against a frame-level pixel/address model.
module tb_bg_stream_fetch;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic              mode32;
    logic [ADDR_W-1:0] base_addr;
    logic              ce_pix;
    logic              hblank;
    logic              vblank;
    logic              vs;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_data;
    logic [7:0]        bg_r;
    logic [7:0]        bg_g;
    logic [7:0]        bg_b;
    logic [7:0]        bg_a;
    logic              underrun;

    int checks   = 0;
    int failures = 0;

    int                lat_lo = 4;
    int                lat_hi = 4;
    bit                stall  = 1'b0;
    logic [31:0]       seed;
    logic [ADDR_W-1:0] req_log [$];

    always #5 clk = ~clk;

    bg_stream_fetch #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .mode32    (mode32),
        .base_addr (base_addr),
        .ce_pix    (ce_pix),
        .hblank    (hblank),
        .vblank    (vblank),
        .vs        (vs),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .bg_r      (bg_r),
        .bg_g      (bg_g),
        .bg_b      (bg_b),
        .bg_a      (bg_a),
        .underrun  (underrun)
    );

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        if (a == 24'h000300) return 32'hF800_001F;
        return {a[15:0] ^ seed[31:16], a[15:0] ^ seed[15:0]};
    endfunction

    // Pixel k of a frame, assuming no underrun: word index k (RGBA) or k/2 (RGB565).
    function automatic logic [31:0] exp_pix(input logic [ADDR_W-1:0] base, input int k, input bit m32);
        logic [31:0] w;
        logic [15:0] p;
        if (m32) return mem_word(ADDR_W'(base + 2 * k));
        w = mem_word(ADDR_W'(base + 2 * (k / 2)));
        p = (k % 2 == 1) ? w[31:16] : w[15:0];
        return {8'hFF, p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // SDRAM channel model: one request at a time, random latency, single-cycle ack.
    initial begin : mem_model
        int                cnt;
        bit                busy;
        logic [ADDR_W-1:0] addr;
        cnt = 0; busy = 1'b0; addr = '0;
        mem_ack = 1'b0; mem_data = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end else if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_word(addr);
                end
            end
            if (!busy && mem_req === 1'b1 && !stall) begin
                busy = 1'b1;
                addr = mem_addr;
                cnt  = int'($urandom_range(lat_hi, lat_lo));
                req_log.push_back(mem_addr);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [ADDR_W-1:0] base, input bit m32);
        @(negedge clk);
        base_addr = base; mode32 = m32; enable = 1'b1; vs = 1'b1;
        req_log.delete();
        @(negedge clk);
        vs = 1'b0;
    endtask

    task automatic idle_dut();
        @(negedge clk);
        enable = 1'b0; ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0; stall = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic pixel(input bit active, input int gap, output logic [31:0] got);
        @(negedge clk);
        ce_pix = 1'b1; hblank = !active;
        @(negedge clk);
        ce_pix = 1'b0; hblank = 1'b0;
        got = {bg_a, bg_b, bg_g, bg_r};
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_addr_seq(input string name, input logic [ADDR_W-1:0] base, input int first);
        int bad = -1;
        for (int i = first; i < req_log.size(); i++)
            if (bad < 0 && req_log[i] !== ADDR_W'(base + 2 * (i - first))) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: request %0d addr %h expected %h", name, bad, req_log[bad],
                     ADDR_W'(base + 2 * (bad - first)));
        end
    endtask

    task automatic test_reset();
        logic [31:0] got;
        int n;
        checks++;
        if ({mem_req, underrun, mem_addr} !== '0) begin
            failures++; $display("FAIL por_state: req=%b underrun=%b addr=%h expected 0", mem_req, underrun, mem_addr);
        end
        checks++;
        if ({bg_a, bg_b, bg_g, bg_r} !== 32'h0) begin
            failures++; $display("FAIL por_pixel: got %h expected 0", {bg_a, bg_b, bg_g, bg_r});
        end
        @(negedge clk);
        reset_n = 1'b1;
        lat_lo = 8; lat_hi = 8;
        start_frame(24'h0000A0, 1'b1);
        repeat (60) @(negedge clk);
        pixel(1'b1, 0, got);
        checks++;
        if (got !== exp_pix(24'h0000A0, 0, 1'b1)) begin
            failures++; $display("FAIL reset_first_pix: got %h expected %h", got, exp_pix(24'h0000A0, 0, 1'b1));
        end
        n = 0;
        while (mem_req !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++;
        if (mem_req !== 1'b1) begin
            failures++; $display("FAIL reset_wait_req: mem_req=%b expected 1", mem_req);
        end
        #2;
        reset_n = 1'b0; enable = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== '0) begin
            failures++; $display("FAIL reset_async_req: req=%b addr=%h expected 0/0", mem_req, mem_addr);
        end
        checks++;
        if ({bg_a, bg_b, bg_g, bg_r} !== 32'h0) begin
            failures++; $display("FAIL reset_async_pix: got %h expected 0", {bg_a, bg_b, bg_g, bg_r});
        end
        repeat (12) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        enable = 1'b1; ce_pix = 1'b1; hblank = 1'b0; vblank = 1'b0;
        @(negedge clk);
        ce_pix = 1'b0;
        checks++;
        if ({bg_a, bg_b, bg_g, bg_r} !== 32'h0 || underrun !== 1'b1) begin
            failures++; $display("FAIL reset_late_ack: pix=%h underrun=%b expected 0/1", {bg_a, bg_b, bg_g, bg_r}, underrun);
        end
        idle_dut();
    endtask

    task automatic test_rgba32();
        logic [31:0] got;
        int bad = -1;
        logic [31:0] bad_got = '0;
        lat_lo = 1; lat_hi = 4;
        start_frame(24'h000100, 1'b1);
        repeat (40) @(negedge clk);
        checks++;
        if (req_log.size() != DEPTH || mem_req !== 1'b0) begin
            failures++; $display("FAIL rgba_prefetch: reqs=%0d req=%b expected %0d/0", req_log.size(), mem_req, DEPTH);
        end
        for (int k = 0; k < 12; k++) begin
            pixel(1'b1, int'($urandom_range(8, 6)), got);
            if (bad < 0 && got !== exp_pix(24'h000100, k, 1'b1)) begin bad = k; bad_got = got; end
        end
        checks++;
        if (bad >= 0) begin
            failures++; $display("FAIL rgba_pixels: pixel %0d got %h expected %h", bad, bad_got, exp_pix(24'h000100, bad, 1'b1));
        end
        checks++;
        if (underrun !== 1'b0) begin
            failures++; $display("FAIL rgba_underrun: got %b expected 0", underrun);
        end
        check_addr_seq("rgba_addr_seq", 24'h000100, 0);
        @(negedge clk);
        enable = 1'b0; ce_pix = 1'b1;
        @(negedge clk);
        ce_pix = 1'b0;
        checks++;
        if ({bg_a, bg_b, bg_g, bg_r} !== 32'h0 || mem_req !== 1'b0) begin
            failures++; $display("FAIL enable_off: pix=%h req=%b expected 0/0", {bg_a, bg_b, bg_g, bg_r}, mem_req);
        end
        idle_dut();
    endtask

    task automatic test_rgb565();
        logic [31:0] got;
        logic [31:0] exp;
        int k = 0;
        int bad = -1;
        lat_lo = 1; lat_hi = 4;
        start_frame(24'h000300, 1'b0);
        repeat (40) @(negedge clk);
        pixel(1'b1, 5, got);
        checks++;
        if (got !== 32'hFF0000FF) begin
            failures++; $display("FAIL rgb565_pix0: got %h expected ff0000ff", got);
        end
        pixel(1'b1, 5, got);
        checks++;
        if (got !== 32'hFFFF0000) begin
            failures++; $display("FAIL rgb565_pix1: got %h expected ffff0000", got);
        end
        k = 2;
        for (int i = 0; i < 24; i++) begin
            bit act = ($urandom_range(3, 0) != 0);
            pixel(act, int'($urandom_range(8, 5)), got);
            exp = act ? exp_pix(24'h000300, k, 1'b0) : 32'h0;
            if (bad < 0 && got !== exp) begin
                bad = i;
                failures++; $display("FAIL rgb565_random: step %0d got %h expected %h", i, got, exp);
            end
            if (act) k++;
        end
        checks++;
        repeat (40) @(negedge clk);
        checks++;
        if (req_log.size() != k / 2 + DEPTH) begin
            failures++; $display("FAIL rgb565_req_count: got %0d expected %0d", req_log.size(), k / 2 + DEPTH);
        end
        check_addr_seq("rgb565_addr_seq", 24'h000300, 0);
        idle_dut();
    endtask

    task automatic test_underrun();
        logic [31:0] got;
        lat_lo = 1; lat_hi = 4;
        start_frame(24'h000400, 1'b1);
        repeat (40) @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            pixel(1'b1, 3, got);
            checks++;
            if (got !== exp_pix(24'h000400, k, 1'b1)) begin
                failures++; $display("FAIL underrun_drain: pixel %0d got %h expected %h", k, got, exp_pix(24'h000400, k, 1'b1));
            end
        end
        checks++;
        if (underrun !== 1'b0) begin
            failures++; $display("FAIL underrun_early: got %b expected 0", underrun);
        end
        for (int k = 0; k < 2; k++) begin
            pixel(1'b1, 6, got);
            checks++;
            if (got !== 32'h0 || underrun !== 1'b1) begin
                failures++; $display("FAIL underrun_empty: pix=%h underrun=%b expected 0/1", got, underrun);
            end
        end
        stall = 1'b0;
        repeat (10) @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            failures++; $display("FAIL underrun_clear: got %b expected 0", underrun);
        end
        idle_dut();
    endtask

    task automatic test_discard();
        logic [31:0] got;
        int n = 0;
        lat_lo = 8; lat_hi = 8;
        start_frame(24'h000150, 1'b1);
        while (req_log.size() < 1 && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        base_addr = 24'h000200; vs = 1'b1;
        lat_lo = 1; lat_hi = 4;
        @(negedge clk);
        vs = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (req_log.size() < 3) begin
            failures++; $display("FAIL discard_reqs: got %0d requests expected at least 3", req_log.size());
        end else if (req_log[0] !== 24'h000150 || req_log[1] !== 24'h000200) begin
            failures++; $display("FAIL discard_addr: got %h,%h expected 000150,000200", req_log[0], req_log[1]);
        end
        check_addr_seq("discard_addr_seq", 24'h000200, 1);
        for (int k = 0; k < 4; k++) begin
            pixel(1'b1, 6, got);
            checks++;
            if (got !== exp_pix(24'h000200, k, 1'b1)) begin
                failures++; $display("FAIL discard_pix: pixel %0d got %h expected %h", k, got, exp_pix(24'h000200, k, 1'b1));
            end
        end
        idle_dut();
    endtask

    task automatic test_fill_limit();
        logic [31:0] got;
        lat_lo = 1; lat_hi = 1;
        start_frame(24'h000500, 1'b1);
        repeat (40) @(negedge clk);
        checks++;
        if (req_log.size() != DEPTH || mem_req !== 1'b0) begin
            failures++; $display("FAIL fill_limit: reqs=%0d req=%b expected %0d/0", req_log.size(), mem_req, DEPTH);
        end
        pixel(1'b1, 20, got);
        checks++;
        if (req_log.size() != DEPTH + 1 || got !== exp_pix(24'h000500, 0, 1'b1)) begin
            failures++; $display("FAIL fill_refill: reqs=%0d pix=%h expected %0d/%h", req_log.size(), got,
                                 DEPTH + 1, exp_pix(24'h000500, 0, 1'b1));
        end
        idle_dut();
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode32 = 1'b1; base_addr = '0;
        ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0; vs = 1'b0;
        seed = $urandom;
        repeat (3) @(negedge clk);
        test_reset();
        test_rgba32();
        test_rgb565();
        test_underrun();
        test_discard();
        test_fill_limit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
